// File: rtl/rf_pkg.sv
// Shared widths and state/grant types for the register-file writeback arbiter.
package rf_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;

    typedef enum logic {CLEAR, RUN} rf_arb_state_t;
    typedef enum logic {GNT_A, GNT_B} rf_gnt_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback requester handshakes plus the register-file write port.
interface rf_wb_arbiter_if;
    import rf_pkg::*;

    logic            a_valid;
    logic            a_ready;
    logic [AW-1:0]   a_addr;
    logic [XLEN-1:0] a_data;
    logic            b_valid;
    logic            b_ready;
    logic [AW-1:0]   b_addr;
    logic [XLEN-1:0] b_data;
    logic            rf_wr_en;
    logic [AW-1:0]   rf_wr_addr;
    logic [XLEN-1:0] rf_wr_data;
    logic            init_done;

    // Requester/observer side
    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready, rf_wr_en, rf_wr_addr, rf_wr_data, init_done
    );

    // Arbiter side
    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready, rf_wr_en, rf_wr_addr, rf_wr_data, init_done
    );

endinterface

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin arbiter; gnt[0]=A, gnt[1]=B, one-hot or zero.
module rr_arb2
    import rf_pkg::*;
(
    input  logic [1:0] req,
    input  rf_gnt_t    last,
    input  logic       en,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                // On a tie, favour whoever did not win last time
                2'b11:   gnt = (last == GNT_A) ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Owns the register-file write port: clears x1..x31 after reset, then
// round-robins writebacks from the ALU (A) and load unit (B).
module rf_wb_arbiter
    import rf_pkg::*;
(
    input logic            clk,
    input logic            rst_n,
    rf_wb_arbiter_if.slave bus
);

    rf_arb_state_t   state_q, state_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
    rf_gnt_t         last_q, last_d;
    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [XLEN-1:0] wr_data_q, wr_data_d;
    logic            init_done_q, init_done_d;

    logic [1:0]      gnt;
    logic [AW-1:0]   sel_addr;
    logic [XLEN-1:0] sel_data;

    rr_arb2 u_rr_arb2 (
        .req  ({bus.b_valid, bus.a_valid}),
        .last (last_q),
        .en   (state_q == RUN),
        .gnt  (gnt)
    );

    assign bus.a_ready    = gnt[0];
    assign bus.b_ready    = gnt[1];
    assign bus.rf_wr_en   = wr_en_q;
    assign bus.rf_wr_addr = wr_addr_q;
    assign bus.rf_wr_data = wr_data_q;
    assign bus.init_done  = init_done_q;

    assign sel_addr = gnt[1] ? bus.b_addr : bus.a_addr;
    assign sel_data = gnt[1] ? bus.b_data : bus.a_data;

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        last_d      = last_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        init_done_d = init_done_q;
        unique case (state_q)
            CLEAR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = clr_cnt_q;
                wr_data_d = '0;
                clr_cnt_d = clr_cnt_q + AW'(1);
                if (clr_cnt_q == AW'(NREG - 1)) begin
                    state_d     = RUN;
                    init_done_d = 1'b1;
                end
            end
            RUN: begin
                if (|gnt) begin
                    last_d = gnt[1] ? GNT_B : GNT_A;
                    // x0 writes are accepted but never reach the array
                    if (sel_addr != '0) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = sel_addr;
                        wr_data_d = sel_data;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= AW'(1);
            last_q      <= GNT_B;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            last_q      <= last_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            init_done_q <= init_done_d;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter with a behavioural register-file model.
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    logic rf_fill = 1'b0;
    logic [XLEN-1:0] rf_mem [NREG];

    rf_wb_arbiter_if bus ();

    rf_wb_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Register array with no reset: preloaded with a pattern, then written by the port
    always @(posedge clk) begin
        if (rf_fill) begin
            for (int i = 0; i < int'(NREG); i++) rf_mem[i] <= 32'hA5A5_A5A5;
        end else if (bus.rf_wr_en) begin
            rf_mem[bus.rf_wr_addr] <= bus.rf_wr_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Expect the 31 clear writes; a_ready must stay low while A is held
    task automatic walk(input string tag);
        for (int i = 1; i <= 31; i++) begin
            step();
            check({tag, " walk en"}, 32'(bus.rf_wr_en), 32'd1);
            check({tag, " walk addr"}, 32'(bus.rf_wr_addr), 32'(i));
            check({tag, " walk data"}, bus.rf_wr_data, 32'd0);
            check({tag, " walk done"}, 32'(bus.init_done), 32'(i == 31));
            if (i < 31) begin
                check({tag, " walk a_ready"}, 32'(bus.a_ready), 32'd0);
                check({tag, " walk b_ready"}, 32'(bus.b_ready), 32'd0);
            end
        end
    endtask

    initial begin
        rst_n       = 1'b1;
        bus.a_valid = 1'b0;
        bus.a_addr  = '0;
        bus.a_data  = '0;
        bus.b_valid = 1'b0;
        bus.b_addr  = '0;
        bus.b_data  = '0;
        rf_fill     = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        check("reset en", 32'(bus.rf_wr_en), 32'd0);
        check("reset addr", 32'(bus.rf_wr_addr), 32'd0);
        check("reset data", bus.rf_wr_data, 32'd0);
        check("reset done", 32'(bus.init_done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rf_fill = 1'b0;
        rst_n   = 1'b1;

        // Clear walk with no requests
        walk("t1");
        step();
        check("t1 idle en", 32'(bus.rf_wr_en), 32'd0);
        check("t1 done held", 32'(bus.init_done), 32'd1);
        check("t1 x17 cleared", rf_mem[17], 32'd0);
        check("t1 x0 untouched", rf_mem[0], 32'hA5A5_A5A5);

        // A held valid across reset and walk
        bus.a_valid = 1'b1;
        bus.a_addr  = 5'd5;
        bus.a_data  = 32'hDEAD_BEEF;
        pulse_reset();
        #1;
        check("t2 reset en", 32'(bus.rf_wr_en), 32'd0);
        check("t2 reset done", 32'(bus.init_done), 32'd0);
        walk("t2");
        check("t2 a_ready in run", 32'(bus.a_ready), 32'd1);
        step();
        bus.a_valid = 1'b0;
        check("t2 wr en", 32'(bus.rf_wr_en), 32'd1);
        check("t2 wr addr", 32'(bus.rf_wr_addr), 32'd5);
        check("t2 wr data", bus.rf_wr_data, 32'hDEAD_BEEF);
        step();
        check("t2 idle en", 32'(bus.rf_wr_en), 32'd0);
        check("t2 addr hold", 32'(bus.rf_wr_addr), 32'd5);

        // B writes x0: accepted, no register-file write
        bus.b_valid = 1'b1;
        bus.b_addr  = 5'd0;
        bus.b_data  = 32'h0000_1234;
        #1;
        check("t4 b_ready", 32'(bus.b_ready), 32'd1);
        check("t4 a_ready", 32'(bus.a_ready), 32'd0);
        step();
        bus.b_valid = 1'b0;
        check("t4 x0 en", 32'(bus.rf_wr_en), 32'd0);
        step();
        check("t4 x0 model", rf_mem[0], 32'hA5A5_A5A5);

        // Contention: A,B,A,B
        bus.a_valid = 1'b1;
        bus.a_addr  = 5'd3;
        bus.a_data  = 32'h0000_0033;
        bus.b_valid = 1'b1;
        bus.b_addr  = 5'd4;
        bus.b_data  = 32'h0000_0044;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("t3 a_ready", 32'(bus.a_ready), 32'(k % 2 == 0));
            check("t3 b_ready", 32'(bus.b_ready), 32'(k % 2 == 1));
            check("t3 one ready", 32'(bus.a_ready & bus.b_ready), 32'd0);
            step();
            check("t3 wr en", 32'(bus.rf_wr_en), 32'd1);
            check("t3 wr addr", 32'(bus.rf_wr_addr), (k % 2 == 0) ? 32'd3 : 32'd4);
            check("t3 wr data", bus.rf_wr_data, (k % 2 == 0) ? 32'h33 : 32'h44);
        end
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        step();
        check("t3 idle en", 32'(bus.rf_wr_en), 32'd0);

        // Same-address pair: A x9=0x11 then B x9=0x22, later one wins
        bus.a_valid = 1'b1;
        bus.a_addr  = 5'd9;
        bus.a_data  = 32'h0000_0011;
        bus.b_valid = 1'b1;
        bus.b_addr  = 5'd9;
        bus.b_data  = 32'h0000_0022;
        #1;
        check("t6 a first", 32'(bus.a_ready), 32'd1);
        step();
        bus.a_valid = 1'b0;
        #1;
        check("t6 b second", 32'(bus.b_ready), 32'd1);
        check("t6 a data out", bus.rf_wr_data, 32'h11);
        step();
        bus.b_valid = 1'b0;
        check("t6 b data out", bus.rf_wr_data, 32'h22);
        step();
        step();
        check("t6 x9 readback", rf_mem[9], 32'h22);

        // Reset in the middle of the walk at x17
        pulse_reset();
        for (int i = 1; i <= 17; i++) begin
            step();
            check("t5 pre addr", 32'(bus.rf_wr_addr), 32'(i));
        end
        rst_n = 1'b0;
        #1;
        check("t5 abort en", 32'(bus.rf_wr_en), 32'd0);
        check("t5 abort addr", 32'(bus.rf_wr_addr), 32'd0);
        check("t5 abort data", bus.rf_wr_data, 32'd0);
        check("t5 abort done", 32'(bus.init_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        walk("t5");
        step();
        check("t5 idle en", 32'(bus.rf_wr_en), 32'd0);
        check("t5 x9 cleared", rf_mem[9], 32'd0);
        check("t5 x31 cleared", rf_mem[31], 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
